// File: rtl/ula_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the
// helper that caps the shift count at the operand width.
package ula_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_ADDI = 5'b00001,
    OP_INC  = 5'b00011,
    OP_SUBD = 5'b00100,
    OP_SLL  = 5'b01000
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    DONE
  } state_t;

  // Shifting by WIDTH or more already clears every bit, so iterate at most WIDTH times.
  function automatic int unsigned cnt_cap(input int unsigned amount, input int unsigned width);
    return (amount > width) ? width : amount;
  endfunction

endpackage

// File: rtl/ula_multiciclo_if.sv
// Request/response bundle for the multi-cycle ALU. The master side issues
// operations and consumes results; the slave side is the ALU itself.
interface ula_multiciclo_if #(
  parameter int WIDTH = 3
);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       controle;
  logic [WIDTH-1:0] operandoA;
  logic [WIDTH-1:0] operandoB;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] resultadoOp;
  logic             Z;
  logic             C;
  logic             S;
  logic             O;
  logic             erro;

  modport master (
    output req_valid, controle, operandoA, operandoB, rsp_ready,
    input  req_ready, rsp_valid, resultadoOp, Z, C, S, O, erro
  );

  modport slave (
    input  req_valid, controle, operandoA, operandoB, rsp_ready,
    output req_ready, rsp_valid, resultadoOp, Z, C, S, O, erro
  );
endinterface

// File: rtl/ula_somador.sv
// Combinational WIDTH-bit adder with carry-in, shared by every arithmetic
// opcode. carry is bit WIDTH of the unsigned sum; overflow flags a signed
// result that does not fit in WIDTH bits.
module ula_somador #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum      = full[WIDTH-1:0];
  assign carry    = full[WIDTH];
  // Same-sign operands producing a different-sign result cannot be represented.
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/ula_multiciclo.sv
// Sequential ALU responder: accepts one request, runs a single-cycle
// arithmetic op or an iterative 1-bit-per-cycle left shift, then holds the
// result and Z/C/S/O flags until the consumer takes them.
// Optional build macro ULA_OVF_STICKY_EN adds clr_sticky / O_sticky.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  ula_multiciclo_if.slave       bus
`ifdef ULA_OVF_STICKY_EN
  ,
  input  logic                  clr_sticky,
  output logic                  O_sticky
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_reg, state_next;
  logic [4:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             z_reg, z_next, c_reg, c_next, s_reg, s_next, o_reg, o_next;
  logic             erro_reg, erro_next;

  logic [WIDTH-1:0] add_b, add_sum, shifted;
  logic             add_cin, add_carry, add_ovf;
  logic [CW-1:0]    cap;

  ula_somador #(.WIDTH(WIDTH)) u_somador (
    .a        (a_reg),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_ovf)
  );

  assign shifted = {work_reg[WIDTH-2:0], 1'b0};
  assign cap     = CW'(cnt_cap(32'(b_reg), WIDTH));

  // Select the adder's second operand and carry-in for the latched opcode.
  always_comb begin
    add_b   = b_reg;
    add_cin = 1'b0;
    case (op_reg)
      OP_ADDI: add_cin = 1'b1;
      OP_INC: begin
        add_b   = '0;
        add_cin = 1'b1;
      end
      OP_SUBD: add_b = ~b_reg;
      default: ;
    endcase
  end

  // Next-state and datapath updates; result/flags change only on completion.
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    cnt_next    = cnt_reg;
    work_next   = work_reg;
    result_next = result_reg;
    z_next      = z_reg;
    c_next      = c_reg;
    s_next      = s_reg;
    o_next      = o_reg;
    erro_next   = erro_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          op_next    = bus.controle;
          a_next     = bus.operandoA;
          b_next     = bus.operandoB;
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = DONE;
        case (op_reg)
          OP_ADD, OP_ADDI, OP_INC, OP_SUBD: begin
            result_next = add_sum;
            z_next      = (add_sum == '0);
            c_next      = add_carry;
            s_next      = add_sum[WIDTH-1];
            o_next      = add_ovf;
            erro_next   = 1'b0;
          end
          OP_SLL: begin
            cnt_next = cap;
            if (cap == '0) begin
              result_next = a_reg;
              z_next      = (a_reg == '0);
              c_next      = 1'b0;
              s_next      = a_reg[WIDTH-1];
              o_next      = 1'b0;
              erro_next   = 1'b0;
            end else begin
              work_next  = a_reg;
              state_next = SHIFT;
            end
          end
          default: begin
            result_next = '0;
            erro_next   = 1'b1;
          end
        endcase
      end
      SHIFT: begin
        work_next = shifted;
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          result_next = shifted;
          z_next      = (shifted == '0);
          c_next      = work_reg[WIDTH-1];
          s_next      = shifted[WIDTH-1];
          o_next      = 1'b0;
          erro_next   = 1'b0;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cnt_reg    <= '0;
      work_reg   <= '0;
      result_reg <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
      s_reg      <= 1'b0;
      o_reg      <= 1'b0;
      erro_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      cnt_reg    <= cnt_next;
      work_reg   <= work_next;
      result_reg <= result_next;
      z_reg      <= z_next;
      c_reg      <= c_next;
      s_reg      <= s_next;
      o_reg      <= o_next;
      erro_reg   <= erro_next;
    end
  end

  assign bus.req_ready   = (state_reg == IDLE);
  assign bus.rsp_valid   = (state_reg == DONE);
  assign bus.resultadoOp = result_reg;
  assign bus.Z           = z_reg;
  assign bus.C           = c_reg;
  assign bus.S           = s_reg;
  assign bus.O           = o_reg;
  assign bus.erro        = erro_reg;

`ifdef ULA_OVF_STICKY_EN
  logic o_sticky_reg, o_sticky_next;
  logic completes;

  assign completes = (state_reg != DONE) && (state_next == DONE);

  // Sticky overflow: a completing op with O=1 beats a simultaneous clear.
  always_comb begin
    o_sticky_next = o_sticky_reg;
    if (completes && o_next) o_sticky_next = 1'b1;
    else if (clr_sticky)     o_sticky_next = 1'b0;
  end

  // Sticky overflow register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_sticky_reg <= 1'b0;
    else       o_sticky_reg <= o_sticky_next;
  end

  assign O_sticky = o_sticky_reg;
`endif

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo: a vector table of
// operations with hand-computed results, flags and latencies, followed by
// backpressure and reset-during-shift sequences.
module tb_ula_multiciclo;
  localparam int WIDTH = 3;

  logic clk;
  logic reset;
`ifdef ULA_OVF_STICKY_EN
  logic clr_sticky;
  logic O_sticky;
`endif

  ula_multiciclo_if #(.WIDTH(WIDTH)) bus ();

  ula_multiciclo #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef ULA_OVF_STICKY_EN
    ,
    .clr_sticky (clr_sticky),
    .O_sticky   (O_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] res;
    logic       z, c, s, o, erro;
    int         lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, return edges from the accept edge until rsp_valid.
  task automatic issue(input logic [4:0] op, input logic [2:0] a, input logic [2:0] b,
                       output int lat);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      tick();
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.controle  = op;
    bus.operandoA = a;
    bus.operandoB = b;
    tick();
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [2:0] v_res;

    //          op        a       b       res     z     c     s     o     erro  lat
    vecs[0]  = '{5'b00000, 3'b001, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{5'b00000, 3'b010, 3'b011, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[2]  = '{5'b00011, 3'b111, 3'b101, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{5'b00100, 3'b011, 3'b001, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{5'b00100, 3'b010, 3'b101, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[5]  = '{5'b01000, 3'b011, 3'b010, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3};
    vecs[6]  = '{5'b01000, 3'b011, 3'b111, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4};
    vecs[7]  = '{5'b00001, 3'b011, 3'b001, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[8]  = '{5'b01000, 3'b101, 3'b000, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{5'b00000, 3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[10] = '{5'b11111, 3'b110, 3'b011, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    vecs[11] = '{5'b01000, 3'b001, 3'b001, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[12] = '{5'b00010, 3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.controle  = '0;
    bus.operandoA = '0;
    bus.operandoB = '0;
    bus.rsp_ready = 1'b0;
`ifdef ULA_OVF_STICKY_EN
    clr_sticky    = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_req_ready", int'(bus.req_ready), 1);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_result",    int'(bus.resultadoOp), 0);
    chk("reset_flags",     int'({bus.Z, bus.C, bus.S, bus.O, bus.erro}), 0);

    // Table of single transactions.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      $display("vec %0d: op=%b a=%b b=%b -> res=%b Z=%b C=%b S=%b O=%b erro=%b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.resultadoOp,
               bus.Z, bus.C, bus.S, bus.O, bus.erro, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_result", i), int'(bus.resultadoOp), int'(vecs[i].res));
      chk($sformatf("v%0d_Z", i), int'(bus.Z), int'(vecs[i].z));
      chk($sformatf("v%0d_C", i), int'(bus.C), int'(vecs[i].c));
      chk($sformatf("v%0d_S", i), int'(bus.S), int'(vecs[i].s));
      chk($sformatf("v%0d_O", i), int'(bus.O), int'(vecs[i].o));
      chk($sformatf("v%0d_erro", i), int'(bus.erro), int'(vecs[i].erro));
      chk($sformatf("v%0d_req_ready_busy", i), int'(bus.req_ready), 0);
      release_rsp();
      chk($sformatf("v%0d_rsp_dropped", i), int'(bus.rsp_valid), 0);
    end

`ifdef ULA_OVF_STICKY_EN
    chk("sticky_set", int'(O_sticky), 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clear", int'(O_sticky), 0);
`endif

    // Backpressure: response held while a new request waits.
    issue(5'b00000, 3'b010, 3'b011, lat);
    chk("bp_latency", lat, 1);
    bus.req_valid = 1'b1;
    bus.controle  = 5'b00000;
    bus.operandoA = 3'b001;
    bus.operandoB = 3'b001;
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("backpressure cycle %0d: rsp_valid=%b req_ready=%b res=%b", k,
               bus.rsp_valid, bus.req_ready, bus.resultadoOp);
      chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
      chk("bp_req_ready", int'(bus.req_ready), 0);
      chk("bp_result",    int'(bus.resultadoOp), 5);
      chk("bp_flags",     int'({bus.Z, bus.C, bus.S, bus.O}), 4'b0011);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_release_idle", int'(bus.req_ready), 1);
    chk("bp_release_rsp",  int'(bus.rsp_valid), 0);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_second_taken", int'(bus.req_ready), 0);
    tick();
    chk("bp_second_valid",  int'(bus.rsp_valid), 1);
    chk("bp_second_result", int'(bus.resultadoOp), 2);
    release_rsp();

    // Reset in the middle of a shift aborts it with no response.
    issue(5'b00000, 3'b001, 3'b001, lat);
    release_rsp();
    bus.req_valid = 1'b1;
    bus.controle  = 5'b01000;
    bus.operandoA = 3'b011;
    bus.operandoB = 3'b111;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_result",    int'(bus.resultadoOp), 0);
    chk("rst_mid_flags",     int'({bus.Z, bus.C, bus.S, bus.O, bus.erro}), 0);
    chk("rst_mid_rsp_valid", int'(bus.rsp_valid), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_after_req_ready", int'(bus.req_ready), 1);
    v_res = 3'b000;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.rsp_valid) v_res = 3'b111;
    end
    $display("after mid-shift reset: rsp_valid seen=%0d req_ready=%b", v_res != 0, bus.req_ready);
    chk("rst_after_no_rsp", int'(v_res), 0);
    chk("rst_after_idle",   int'(bus.req_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Sequential ALU responder. It accepts one operation request per transaction over a valid/ready handshake and executes it: single-cycle arithmetic, or an iterative one-bit-per-cycle left shift. It returns the result and registered Z/C/S/O flags over a second valid/ready handshake. It sits between the control unit/sequencer and the datapath, and replaces direct combinational ULA use where backpressure and multi-cycle ops are needed.

Parameters:
WIDTH, 3, operand/result width in bits (two's complement).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
controle  input  5  opcode, sampled on accept.
operandoA  input  WIDTH  operand A, sampled on accept.
operandoB  input  WIDTH  operand B / shift amount, sampled on accept.
rsp_valid  output  1  result and flags valid.
rsp_ready  input  1  consumer takes the response.
resultadoOp  output  WIDTH  registered result.
Z  output  1  zero flag, registered.
C  output  1  carry flag, registered.
S  output  1  sign flag, registered.
O  output  1  signed-overflow flag, registered.
erro  output  1  last completed opcode was illegal.

Behaviour:
- Reset: asynchronous and active-high.
  - State goes to IDLE, counter clears.
  - resultadoOp, Z, C, S, O, erro and rsp_valid all go to 0.
  - req_ready=1 immediately after reset deassertion.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch op/A/B and go to EXEC.
  - EXEC:
    - Arithmetic op: register result and flags, go to DONE.
    - SLL: load cnt=min(B unsigned, WIDTH). If cnt==0, go to DONE with result=A. Otherwise go to SHIFT.
    - Illegal op: go to DONE.
  - SHIFT: each cycle, shift left by 1, C takes the bit shifted out, cnt decrements. When cnt reaches 0, set flags and go to DONE.
  - DONE: rsp_valid=1. Outputs are held stable until rsp_ready. On rsp_ready, go to IDLE. rsp_valid drops on the same edge.
- req_ready=0 in every state except IDLE. Requests presented outside IDLE are ignored and not queued.
- Latency from the accept edge to rsp_valid high:
  - Arithmetic and illegal ops: 1 cycle.
  - SLL: 1+min(B,WIDTH) cycles.
- Opcodes:
  - ADD 00000: A+B.
  - ADDI 00001: A+B+1.
  - INC 00011: A+1.
  - SUBD 00100: A+~B (=A-B-1).
  - SLL 01000: A<<B.
- Arithmetic width rules:
  - Computed as a WIDTH+1 bit unsigned sum of A, the second operand and cin.
  - C = bit WIDTH of that sum. For SUBD, C=1 iff A>B unsigned.
  - O=1 iff the exact signed result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - S = result MSB. Z = (result==0).
- SLL flags: O=0. C = last bit shifted out, 0 if cnt==0. S and Z as above.
- Illegal opcode: resultadoOp=0, erro=1, Z/C/S/O keep their previous values.
- Any legal completion clears erro.
- Flags and result update only on completion and hold through IDLE until the next completion.
- Reset during SHIFT or DONE aborts the operation. No response is issued.

Optional Feature:
ULA_OVF_STICKY_EN
- Defined: adds input clr_sticky (1 bit) and output O_sticky (1 bit, reset 0).
  - O_sticky sets on any completion with O=1.
  - O_sticky clears on clr_sticky=1 at a clock edge.
  - If set and clear coincide, set wins.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package ula_pkg:
  - Opcode enum (5-bit: ADD, ADDI, INC, SUBD, SLL).
  - State enum (IDLE, EXEC, SHIFT, DONE).
  - Function computing the cnt cap.
- Sub-module ula_somador: combinational WIDTH-parameterised adder with inputs a, b, cin and outputs sum, carry, overflow. Shared by ADD/ADDI/INC/SUBD.

Test Plan:
- ADD, A=001, B=111 -> after 1 cycle: rsp_valid=1, resultadoOp=000, Z=1, C=1, S=0, O=0.
- ADD 010+011 -> 101, O=1, S=1, C=0, Z=0. Then INC 111 -> 000, Z=1, C=1, O=0.
- SUBD, A=011, B=001 -> 001, C=1, O=0, S=0. Then SUBD, A=010, B=101 -> 100, O=1, S=1, C=0.
- SLL, A=011, B=010 -> rsp_valid exactly 3 cycles after accept; 100, C=1, S=1, O=0. Then SLL with B=111 -> 000, Z=1, 4-cycle latency.
- Backpressure: hold rsp_ready=0 for 4 cycles while req_valid=1 with new operands -> result/flags stable, req_ready=0, second request not taken until the cycle after rsp_ready.
- Illegal opcode 11111 after ADD (flags Z=1, C=1) -> resultadoOp=000, erro=1, flags unchanged. Separately, assert reset mid-SHIFT -> all outputs 0, req_ready=1, no rsp_valid.
